// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard to UART bridge.
//   - set-2 scan-code constants for the prefix and special keys
//   - decoder state enum
//   - scan_to_ascii(code, shift) -> {valid, ascii}
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_t;

  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] ch;
    logic       hit;
    ch  = 8'h00;
    hit = 1'b1;
    case (code)
      8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
      8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
      8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
      8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
      8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
      8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
      8'h35: ch = "y";  8'h1A: ch = "z";
      8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
      8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
      8'h3E: ch = "8";  8'h46: ch = "9";
      SC_SPACE: ch = 8'h20;
      SC_ENTER: ch = 8'h0D;
      default:  hit = 1'b0;
    endcase
    // Uppercase letters sit exactly 0x20 below their lowercase forms.
    if (hit && shift && ch >= "a" && ch <= "z") ch = ch - 8'h20;
    return {hit, ch};
  endfunction

endpackage

// File: rtl/ps2_uart_bridge_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
//   clk, rst          system clock, synchronous active-high reset
//   i_ps2_clk/data    raw asynchronous PS/2 lines
//   o_byte/o_valid    received data byte with a one-cycle valid pulse
//   o_err             one-cycle pulse on a parity or stop-bit error
// A partial frame is discarded after TIMEOUT_CYC cycles without a falling edge.
module ps2_rx #(
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    r_clk_sync, r_data_sync;
  logic          r_clk_prev, r_fall, r_data_smp;
  logic [3:0]    r_bit_cnt;   // 0 = idle, 1..9 = data+parity, 10 = expecting stop
  logic [8:0]    r_shift;     // {parity, d7..d0} once complete
  logic [TW-1:0] r_timer;

  // Idle PS/2 lines are high; resetting the synchronisers high avoids a
  // spurious falling edge right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_fall      <= 1'b0;
      r_data_smp  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[1];
      r_fall      <= r_clk_prev & ~r_clk_sync[1];
      r_data_smp  <= r_data_sync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 9'd0;
      r_timer   <= '0;
      o_byte    <= 8'd0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      // NOTE: pulse outputs get a default of 0 here and are raised below only
      // in the cycle that needs them, so each pulse lasts exactly one cycle.
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (r_fall) begin
        r_timer <= '0;
        if (r_bit_cnt == 4'd0) begin
          if (!r_data_smp) r_bit_cnt <= 4'd1;   // a high start bit is ignored
        end else if (r_bit_cnt < 4'd10) begin
          r_shift   <= {r_data_smp, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
          r_bit_cnt <= 4'd0;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (r_data_smp && (^r_shift)) begin
            o_byte  <= r_shift[7:0];
            o_valid <= 1'b1;
          end else begin
            o_err <= 1'b1;
          end
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
          r_bit_cnt <= 4'd0;
          r_timer   <= '0;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_uart_bridge.sv
// ps2_uart_bridge: PS/2 keyboard to 8N1 UART bridge.
//   clk, rst     system clock, synchronous active-high reset
//   ps2k_clk     PS/2 clock (asynchronous)     ps2k_data  PS/2 data (asynchronous)
//   rs232_tx     UART output, idle high        rx_err     one-cycle frame-error pulse
//   fifo_ovf     sticky overflow flag          fifo_level current FIFO occupancy
// Scan codes are decoded to ASCII (or forwarded raw), buffered and serialised.
module ps2_uart_bridge
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int FIFO_DEPTH  = 16,
  parameter int ASCII_MODE  = 1,
  parameter int TIMEOUT_CYC = CLK_HZ / 500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2k_clk,
  input  logic                          ps2k_data,
  output logic                          rs232_tx,
  output logic                          rx_err,
  output logic                          fifo_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(BAUD_DIV);

  logic [7:0]    w_rx_byte;
  logic          w_rx_valid, w_rx_err;
  logic [8:0]    w_ascii;
  dec_state_t    r_dec_state;
  logic          r_shift_key, r_push;
  logic [7:0]    r_push_data;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic          w_full, w_empty, w_push, w_pop;
  logic          r_hold_valid;
  logic [7:0]    r_hold;
  logic          r_tx_busy, r_tx_line;
  logic [3:0]    r_tx_bit;
  logic [CW-1:0] r_baud_cnt;
  logic [8:0]    r_tx_frame;
  logic          w_bit_end, w_last_bit, w_load;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (ps2k_clk),
    .i_ps2_data (ps2k_data),
    .o_byte     (w_rx_byte),
    .o_valid    (w_rx_valid),
    .o_err      (w_rx_err)
  );

  assign w_ascii = scan_to_ascii(w_rx_byte, r_shift_key);

  // Make/break/shift decoder; r_push is a one-cycle push request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_state <= DEC_IDLE;
      r_shift_key <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= 8'd0;
    end else begin
      r_push <= 1'b0;
      if (w_rx_valid) begin
        if (ASCII_MODE == 0) begin
          r_push      <= 1'b1;
          r_push_data <= w_rx_byte;
        end else begin
          case (r_dec_state)
            DEC_IDLE: begin
              if (w_rx_byte == SC_BREAK)      r_dec_state <= DEC_BREAK;
              else if (w_rx_byte == SC_EXT)   r_dec_state <= DEC_EXT;
              else if (w_rx_byte == SC_LSHIFT || w_rx_byte == SC_RSHIFT) r_shift_key <= 1'b1;
              else {r_push, r_push_data} <= w_ascii;
            end
            DEC_BREAK: begin
              if (w_rx_byte == SC_LSHIFT || w_rx_byte == SC_RSHIFT) r_shift_key <= 1'b0;
              r_dec_state <= DEC_IDLE;
            end
            DEC_EXT:  r_dec_state <= (w_rx_byte == SC_BREAK) ? DEC_EXT_BREAK : DEC_IDLE;
            default:  r_dec_state <= DEC_IDLE;
          endcase
        end
      end
    end
  end

  // FIFO. A push while full is still accepted when a pop frees a slot.
  assign w_full  = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = r_push && (!w_full || w_pop);

  // UART framing helpers. The next byte is popped one cycle before the stop
  // bit ends so it can start on the line with no gap.
  assign w_bit_end  = r_tx_busy && (r_baud_cnt == CW'(BAUD_DIV - 1));
  assign w_last_bit = (r_tx_bit == 4'd9);
  assign w_load     = r_hold_valid && (!r_tx_busy || (w_bit_end && w_last_bit));
  assign w_pop      = !w_empty && !r_hold_valid &&
                      (!r_tx_busy || (w_last_bit && r_baud_cnt == CW'(BAUD_DIV - 2)));

  // NOTE: the storage array has no reset; pointers and level alone say which
  // entries are live, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (r_push && !w_push) r_ovf <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // UART transmitter: start bit from the load itself, then 8 data bits and
  // the stop bit shifted out of r_tx_frame, BAUD_DIV cycles each.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_busy    <= 1'b0;
      r_tx_bit     <= 4'd0;
      r_baud_cnt   <= '0;
      r_tx_frame   <= '1;
      r_tx_line    <= 1'b1;
      r_hold_valid <= 1'b0;
      r_hold       <= 8'd0;
    end else begin
      if (w_load) begin
        r_tx_frame   <= {1'b1, r_hold};
        r_tx_line    <= 1'b0;
        r_tx_bit     <= 4'd0;
        r_baud_cnt   <= '0;
        r_tx_busy    <= 1'b1;
        r_hold_valid <= 1'b0;
      end else if (r_tx_busy) begin
        if (w_bit_end) begin
          r_baud_cnt <= '0;
          if (w_last_bit) begin
            r_tx_busy <= 1'b0;
            r_tx_line <= 1'b1;
          end else begin
            r_tx_bit   <= r_tx_bit + 4'd1;
            r_tx_line  <= r_tx_frame[0];
            r_tx_frame <= {1'b1, r_tx_frame[8:1]};
          end
        end else begin
          r_baud_cnt <= r_baud_cnt + CW'(1);
        end
      end
      if (w_pop) begin
        r_hold       <= r_mem[r_rd_ptr];
        r_hold_valid <= 1'b1;
      end
    end
  end

  assign rs232_tx   = r_tx_line;
  assign rx_err     = w_rx_err;
  assign fifo_ovf   = r_ovf;
  assign fifo_level = r_level;

endmodule
